// File: rtl/qea_state_drain.sv
// qea_state_drain: sweeps the QEA state RAM after core completion and streams
// one complex amplitude per beat, tagged with its basis index and probability.
module qea_state_drain #(
    parameter int unsigned PE_NUM_WIDTH     = 2,
    parameter int unsigned PE_NUM           = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned STATE_DATA_WIDTH = DATA_WIDTH * 2,
    parameter int unsigned STATE_ADDR_WIDTH = 16,
    parameter int unsigned MAX_QBIT_WIDTH   = 6,
    parameter int unsigned NUM_FRAC_BIT     = 30,
    parameter int unsigned RD_LAT           = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
    input  logic                                   i_complete,
    output logic [PE_NUM-1:0]                      o_state_ena,
    output logic [PE_NUM-1:0]                      o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
    output logic                                   o_amp_valid,
    input  logic                                   i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0]            o_amp_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_idx,
    output logic [DATA_WIDTH-1:0]                  o_amp_prob,
    output logic                                   o_amp_last,
    output logic                                   o_busy,
    output logic                                   o_done
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned ACC_W = 2 * DATA_WIDTH + 1;
    localparam int unsigned ROW_W = PE_NUM * STATE_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StStream,
        StDone
    } state_e;

    state_e                      state_q, state_d;
    logic                        complete_q;
    logic [STATE_ADDR_WIDTH-1:0] row_q, row_d;
    logic [STATE_ADDR_WIDTH-1:0] last_row_q, last_row_d;
    logic [PE_NUM_WIDTH-1:0]     lane_q, lane_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ROW_W-1:0]            row_buf_q;
    logic                        capture;
    logic                        trigger;

    logic [MAX_QBIT_WIDTH-1:0]   row_shift;
    logic [STATE_ADDR_WIDTH:0]   row_count;
    logic [STATE_ADDR_WIDTH-1:0] last_row_next;

    logic [STATE_DATA_WIDTH-1:0]   lane_data;
    logic signed [2*DATA_WIDTH-1:0] re_ext, im_ext, sq_re, sq_im;
    logic [ACC_W-1:0]              acc, acc_shr;
    logic [DATA_WIDTH-1:0]         prob;
    logic                          lane_is_last;

    // Only rising edges seen while idle start a sweep.
    assign trigger = i_complete & ~complete_q & (state_q == StIdle);

    // Last row index from the qubit count; row count is capped by the address width.
    always_comb begin
        row_shift     = '0;
        row_count     = '0;
        last_row_next = '0;
        if (i_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
            row_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
            if (row_shift >= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH)) begin
                last_row_next = '1;
            end else begin
                row_count     = (STATE_ADDR_WIDTH + 1)'(1) << row_shift;
                last_row_next = STATE_ADDR_WIDTH'(row_count - 1'b1);
            end
        end
    end

    // Select the current lane; lane 0 sits in the most-significant slice.
    always_comb begin
        lane_data = '0;
        for (int unsigned l = 0; l < PE_NUM; l++) begin
            if (lane_q == PE_NUM_WIDTH'(l)) begin
                lane_data = row_buf_q[(PE_NUM-1-l)*STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
            end
        end
    end

    // Squared magnitude, shifted back to the component scale, saturating.
    always_comb begin
        re_ext  = {{DATA_WIDTH{lane_data[STATE_DATA_WIDTH-1]}},
                   lane_data[STATE_DATA_WIDTH-1 -: DATA_WIDTH]};
        im_ext  = {{DATA_WIDTH{lane_data[DATA_WIDTH-1]}}, lane_data[DATA_WIDTH-1:0]};
        sq_re   = re_ext * re_ext;
        sq_im   = im_ext * im_ext;
        // Squares are non-negative, so zero extension into the wider sum is safe.
        acc     = {1'b0, sq_re} + {1'b0, sq_im};
        acc_shr = acc >> NUM_FRAC_BIT;
        prob    = (|acc_shr[ACC_W-1:DATA_WIDTH]) ? '1 : acc_shr[DATA_WIDTH-1:0];
    end

    assign lane_is_last = (lane_q == PE_NUM_WIDTH'(PE_NUM - 1));

    // Next-state logic for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        last_row_d = last_row_q;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d    = StRead;
                    row_d      = '0;
                    lane_d     = '0;
                    last_row_d = last_row_next;
                end
            end
            StRead: begin
                state_d = StWait;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            StWait: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    lane_d  = '0;
                    state_d = StStream;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStream: begin
                if (i_amp_ready) begin
                    if (lane_is_last) begin
                        lane_d = '0;
                        if (row_q == last_row_q) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = StRead;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters, edge detector and row buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            complete_q <= 1'b0;
            row_q      <= '0;
            last_row_q <= '0;
            lane_q     <= '0;
            cnt_q      <= '0;
            row_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            complete_q <= i_complete;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            if (capture) begin
                row_buf_q <= i_state_dout;
            end
        end
    end

    assign o_state_ena   = {PE_NUM{state_q == StRead}};
    assign o_state_wea   = '0;
    assign o_state_addra = (state_q == StRead) ? row_q : '0;
    assign o_amp_valid   = (state_q == StStream);
    assign o_amp_data    = lane_data;
    assign o_amp_idx     = {row_q, lane_q};
    assign o_amp_prob    = prob;
    assign o_amp_last    = (state_q == StStream) && (row_q == last_row_q) && lane_is_last;
    assign o_busy        = (state_q == StRead) || (state_q == StWait) || (state_q == StStream);
    assign o_done        = (state_q == StDone);

endmodule
